// File: rtl/rst_sequencer_if.sv
// Handshake bundle between the reset sequencer and the subsystems it releases.
// The master side requests restarts and reports stage readiness; the slave side is the sequencer.
interface rst_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    localparam int EW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  rst_req;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_rst;
    logic                  seq_done;
    logic                  seq_err;
    logic [EW-1:0]         err_stage;

    modport master (
        output rst_req, stage_ack,
        input  stage_rst, seq_done, seq_err, err_stage
    );

    modport slave (
        input  rst_req, stage_ack,
        output stage_rst, seq_done, seq_err, err_stage
    );
endinterface

// File: rtl/rst_sequencer.sv
// Multi-stage reset sequencer: releases stage resets in index order, spaced by a fixed gap
// or gated by a per-stage acknowledge with timeout.
//
// state      | meaning
// S_HOLD     | all stages in reset, first cycle after rst/rst_req drop
// S_RELEASE  | counting the gap before stage stage_idx is released
// S_WAIT_ACK | stage stage_idx released, waiting for its acknowledge
// S_DONE     | every stage released (last one acked if gated), sticky
// S_ERROR    | acknowledge timed out for err_stage, sticky
module rst_sequencer #(
    parameter int                    NUM_STAGES     = 4,
    parameter int                    HOLD_CYCLES    = 255,
    parameter int                    TIMEOUT_CYCLES = 1048576,
    parameter logic [NUM_STAGES-1:0] ACK_MASK       = '0
) (
    input  logic clk,
    input  logic rst,
    rst_sequencer_if.slave bus
);
    localparam int EW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int GW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GW-1:0] GAP_TC = GW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] ACK_TC = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [EW-1:0] LAST   = EW'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         stage_idx_q, stage_idx_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]         ack_cnt_q, ack_cnt_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  seq_done_q, seq_done_d;
    logic                  seq_err_q, seq_err_d;
    logic [EW-1:0]         err_stage_q, err_stage_d;

    always_ff @(posedge clk) begin
        if (rst || bus.rst_req) begin
            state_q     <= S_HOLD;
            stage_idx_q <= '0;
            gap_cnt_q   <= '0;
            ack_cnt_q   <= '0;
            stage_rst_q <= '1;
            seq_done_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            stage_rst_q <= stage_rst_d;
            seq_done_q  <= seq_done_d;
            seq_err_q   <= seq_err_d;
            err_stage_q <= err_stage_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        gap_cnt_d   = gap_cnt_q;
        ack_cnt_d   = ack_cnt_q;
        stage_rst_d = stage_rst_q;
        seq_done_d  = seq_done_q;
        seq_err_d   = seq_err_q;
        err_stage_d = err_stage_q;

        case (state_q)
            // One alignment cycle so stage 0 falls HOLD_CYCLES edges after reset drops.
            S_HOLD: begin
                state_d   = S_RELEASE;
                gap_cnt_d = '0;
            end
            S_RELEASE: begin
                if (gap_cnt_q == GAP_TC) begin
                    stage_rst_d[stage_idx_q] = 1'b0;
                    gap_cnt_d                = '0;
                    if (ACK_MASK[stage_idx_q]) begin
                        state_d   = S_WAIT_ACK;
                        ack_cnt_d = '0;
                    end else if (stage_idx_q == LAST) begin
                        state_d    = S_DONE;
                        seq_done_d = 1'b1;
                    end else begin
                        stage_idx_d = stage_idx_q + EW'(1);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            // Ack is checked before the timeout so a same-edge ack wins.
            S_WAIT_ACK: begin
                if (bus.stage_ack[stage_idx_q]) begin
                    if (stage_idx_q == LAST) begin
                        state_d    = S_DONE;
                        seq_done_d = 1'b1;
                    end else begin
                        state_d     = S_RELEASE;
                        stage_idx_d = stage_idx_q + EW'(1);
                        gap_cnt_d   = '0;
                    end
                end else if (ack_cnt_q == ACK_TC) begin
                    state_d     = S_ERROR;
                    seq_err_d   = 1'b1;
                    err_stage_d = stage_idx_q;
                end else begin
                    ack_cnt_d = ack_cnt_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_HOLD;
        endcase
    end

    assign bus.stage_rst = stage_rst_q;
    assign bus.seq_done  = seq_done_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.err_stage = err_stage_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus randomized ack timing, checked every cycle
// against an event-time model of the release schedule.
module tb_rst_sequencer;
    localparam int             N    = 3;
    localparam int             H    = 4;
    localparam int             T    = 16;
    localparam logic [N-1:0]   MASK = 3'b010;
    localparam int             EW   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rst_sequencer_if #(.NUM_STAGES(N)) bus ();

    rst_sequencer #(
        .NUM_STAGES    (N),
        .HOLD_CYCLES   (H),
        .TIMEOUT_CYCLES(T),
        .ACK_MASK      (MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: edge index since restart plus the scheduled edge of the next event.
    int           m_t    = -1;
    int           m_k    = 0;
    int           m_nxt  = H;
    int           m_wdl  = 0;
    int           m_errk = 0;
    bit           m_wait = 0;
    bit           m_done = 0;
    bit           m_err  = 0;
    logic [N-1:0] m_rst  = '1;
    logic [N-1:0] mask_v = MASK;

    // Observed event edges (relative to the latest restart), -1 if not seen.
    int           fall_at [N];
    int           done_at = -1;
    int           err_at  = -1;
    logic [N-1:0] prev_rst  = '1;
    logic         prev_done = 1'b0;
    logic         prev_err  = 1'b0;

    task automatic model_edge(input logic r, input logic rq, input logic [N-1:0] ack);
        if (r || rq) begin
            m_rst = '1; m_done = 0; m_err = 0; m_errk = 0;
            m_t = -1; m_k = 0; m_nxt = H; m_wait = 0;
        end else begin
            m_t++;
            if (!m_done && !m_err) begin
                if (m_wait) begin
                    if (ack[m_k]) begin
                        m_wait = 0;
                        if (m_k == N - 1) m_done = 1;
                        else begin m_k++; m_nxt = m_t + H; end
                    end else if (m_t == m_wdl) begin
                        m_err = 1; m_errk = m_k;
                    end
                end else if (m_t == m_nxt) begin
                    m_rst[m_k] = 1'b0;
                    if (mask_v[m_k]) begin m_wait = 1; m_wdl = m_t + T; end
                    else if (m_k == N - 1) m_done = 1;
                    else begin m_k++; m_nxt = m_t + H; end
                end
            end
        end
    endtask

    task automatic check_int(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rq, input logic [N-1:0] ack);
        logic [EW-1:0] exp_es;
        rst = r;
        bus.rst_req = rq;
        bus.stage_ack = ack;
        @(posedge clk);
        model_edge(r, rq, ack);
        #1;
        exp_es = EW'(m_errk);
        checks++;
        assert (bus.stage_rst === m_rst) else begin
            failures++;
            $error("FAIL stage_rst t=%0d observed=%b expected=%b", m_t, bus.stage_rst, m_rst);
        end
        checks++;
        assert (bus.seq_done === m_done) else begin
            failures++;
            $error("FAIL seq_done t=%0d observed=%b expected=%b", m_t, bus.seq_done, m_done);
        end
        checks++;
        assert (bus.seq_err === m_err) else begin
            failures++;
            $error("FAIL seq_err t=%0d observed=%b expected=%b", m_t, bus.seq_err, m_err);
        end
        checks++;
        assert (bus.err_stage === exp_es) else begin
            failures++;
            $error("FAIL err_stage t=%0d observed=%0d expected=%0d", m_t, bus.err_stage, exp_es);
        end
        if (r || rq) begin
            for (int s = 0; s < N; s++) fall_at[s] = -1;
            done_at = -1;
            err_at  = -1;
        end else begin
            for (int s = 0; s < N; s++)
                if (prev_rst[s] === 1'b1 && bus.stage_rst[s] === 1'b0) fall_at[s] = m_t;
            if (prev_done === 1'b0 && bus.seq_done === 1'b1) done_at = m_t;
            if (prev_err === 1'b0 && bus.seq_err === 1'b1) err_at = m_t;
        end
        prev_rst  = bus.stage_rst;
        prev_done = bus.seq_done;
        prev_err  = bus.seq_err;
    endtask

    function automatic logic [N-1:0] noise();
        logic [N-1:0] v;
        v = N'($urandom);
        return v & ~mask_v;
    endfunction

    initial begin
        logic [N-1:0] a;
        int ack_at;
        rst = 1'b1;
        bus.rst_req = 1'b0;
        bus.stage_ack = '0;
        for (int s = 0; s < N; s++) fall_at[s] = -1;

        // Reset state, then ack[1] sampled from edge 10.
        repeat (3) step(1, 0, '0);
        check_int("reset_stage_rst", int'(bus.stage_rst), 7);
        check_int("reset_seq_done", int'(bus.seq_done), 0);
        for (int i = 0; i < 20; i++) begin
            a = noise();
            a[1] = (m_t + 1 >= 10);
            step(0, 0, a);
        end
        check_int("s1_fall0", fall_at[0], 4);
        check_int("s1_fall1", fall_at[1], 8);
        check_int("s1_fall2", fall_at[2], 14);
        check_int("s1_done", done_at, 14);

        // No ack: timeout at 8+16.
        step(1, 0, '0);
        for (int i = 0; i < 32; i++) step(0, 0, noise());
        check_int("s2_err", err_at, 24);
        check_int("s2_err_stage", int'(bus.err_stage), 1);
        check_int("s2_fall2", fall_at[2], -1);
        check_int("s2_done", done_at, -1);

        // Ack on the timeout edge wins.
        step(1, 0, '0);
        for (int i = 0; i < 32; i++) begin
            a = noise();
            a[1] = (m_t + 1 == 24);
            step(0, 0, a);
        end
        check_int("s3_err", err_at, -1);
        check_int("s3_fall2", fall_at[2], 28);

        // Ack held high from cycle 0.
        step(0, 1, 3'b111);
        for (int i = 0; i < 20; i++) step(0, 0, 3'b010 | noise());
        check_int("s4_fall2", fall_at[2], 13);
        check_int("s4_done", done_at, 13);

        // rst_req pulse mid-sequence (sampled at loop edges 10..12).
        step(1, 0, '0);
        for (int i = 0; i < 30; i++) begin
            step(0, (i >= 10 && i <= 12), 3'b010 | noise());
            if (i == 10) check_int("s5_all_rst", int'(bus.stage_rst), 7);
        end
        check_int("s5_fall0", fall_at[0], 4);
        check_int("s5_fall2", fall_at[2], 13);

        // rst_req out of ERROR restarts the sequence.
        step(1, 0, '0);
        for (int i = 0; i < 26; i++) step(0, 0, noise());
        check_int("s6_err_set", int'(bus.seq_err), 1);
        step(0, 1, '0);
        check_int("s6_err_clr", int'(bus.seq_err), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 3'b010);
        check_int("s6_done", done_at, 13);

        // Randomized ack timing, ack drop-out and occasional restarts.
        for (int round = 0; round < 12; round++) begin
            repeat ($urandom_range(1, 3)) step($urandom_range(0, 1), 1, N'($urandom));
            ack_at = $urandom_range(5, 30);
            for (int i = 0; i < 45; i++) begin
                a = noise();
                a[1] = (i >= ack_at) ? 1'($urandom) | (i == ack_at) : 1'b0;
                step(0, ($urandom_range(0, 59) == 0), a);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
